// File: rtl/wake_sequencer_if.sv
//------------------------------------------------------------------------------
// Module  : wake_sequencer_if
// Brief   : Handshake bundle between wake_sequencer and its three agents.
// Rev     : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface wake_sequencer_if;
    logic       start_i;
    logic [2:0] done_i;
    logic [2:0] wake_o;
    logic [2:0] step_o;
    logic       busy_o;
    logic       finish_o;
    logic       err_o;
    logic [1:0] err_code_o;

    // master: the controlling/agent side; slave: the sequencer itself
    modport master (
        output start_i, done_i,
        input  wake_o, step_o, busy_o, finish_o, err_o, err_code_o
    );

    modport slave (
        input  start_i, done_i,
        output wake_o, step_o, busy_o, finish_o, err_o, err_code_o
    );
endinterface

`default_nettype wire

// File: rtl/wake_sequencer.sv
//------------------------------------------------------------------------------
// Module  : wake_sequencer
// Brief   : Drives agents 0,1,2,1,0,2 through wake/done handshakes with a
//           sticky error. Macro WAKE_SEQ_TIMEOUT_EN compiles in the WAIT timeout.
// Rev     : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module wake_sequencer #(
    parameter int DELAY   = 1,
    parameter int TIMEOUT = 64
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    wake_sequencer_if.slave bus
);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_wake   = 3'd1;
    localparam logic [2:0] c_st_wait   = 3'd2;
    localparam logic [2:0] c_st_gap    = 3'd3;
    localparam logic [2:0] c_st_finish = 3'd4;
    localparam logic [2:0] c_st_error  = 3'd5;

    localparam logic [1:0] c_err_none     = 2'b00;
    localparam logic [1:0] c_err_agent    = 2'b01;
    localparam logic [1:0] c_err_timeout  = 2'b10;
    localparam logic [1:0] c_err_spurious = 2'b11;

    localparam logic [2:0] c_last_step = 3'd5;
    localparam logic [7:0] c_gap_last  = (DELAY > 0) ? 8'(DELAY - 1) : 8'd0;

    function automatic logic [2:0] agent_onehot(input logic [2:0] step);
        logic [2:0] oh;
        case (step)
            3'd0:    oh = 3'b001;
            3'd1:    oh = 3'b010;
            3'd2:    oh = 3'b100;
            3'd3:    oh = 3'b010;
            3'd4:    oh = 3'b001;
            default: oh = 3'b100;
        endcase
        return oh;
    endfunction

    logic [2:0] r_state;
    logic [2:0] r_step;
    logic [7:0] r_gap_cnt;
    logic [1:0] r_code;
    logic [2:0] r_wake;
    logic       r_busy;
    logic       r_finish;
    logic       r_err;

    logic [2:0] w_state_nxt;
    logic [2:0] w_step_nxt;
    logic [7:0] w_gap_nxt;
    logic [1:0] w_code_nxt;
    logic [2:0] w_expected;
    logic       w_timeout;

    assign w_expected = agent_onehot(r_step);

`ifdef WAKE_SEQ_TIMEOUT_EN
    localparam logic [7:0] c_wait_last = 8'(TIMEOUT - 1);

    logic [7:0] r_wait_cnt;

    // Counts WAIT cycles; cleared whenever the block is outside WAIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= 8'd0;
        end else if (r_state == c_st_wait) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end else begin
            r_wait_cnt <= 8'd0;
        end
    end

    assign w_timeout = (r_wait_cnt == c_wait_last);
`else
    logic [7:0] w_unused_timeout;
    assign w_unused_timeout = 8'(TIMEOUT);
    assign w_timeout        = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_gap_nxt   = r_gap_cnt;
        w_code_nxt  = r_code;
        case (r_state)
            c_st_idle: begin
                if (bus.start_i) begin
                    w_state_nxt = c_st_wake;
                    w_step_nxt  = 3'd0;
                end
            end
            c_st_wake: begin
                if (|bus.done_i) begin
                    w_state_nxt = c_st_error;
                    w_code_nxt  = c_err_spurious;
                end else begin
                    w_state_nxt = c_st_wait;
                end
            end
            c_st_wait: begin
                // A valid done wins over a timeout landing in the same cycle
                if (bus.done_i == w_expected) begin
                    if (r_step == c_last_step) begin
                        w_state_nxt = c_st_finish;
                    end else begin
                        w_step_nxt = r_step + 3'd1;
                        if (DELAY == 0) begin
                            w_state_nxt = c_st_wake;
                        end else begin
                            w_state_nxt = c_st_gap;
                            w_gap_nxt   = 8'd0;
                        end
                    end
                end else if (|bus.done_i) begin
                    w_state_nxt = c_st_error;
                    w_code_nxt  = c_err_agent;
                end else if (w_timeout) begin
                    w_state_nxt = c_st_error;
                    w_code_nxt  = c_err_timeout;
                end
            end
            c_st_gap: begin
                if (|bus.done_i) begin
                    w_state_nxt = c_st_error;
                    w_code_nxt  = c_err_spurious;
                end else if (r_gap_cnt == c_gap_last) begin
                    w_state_nxt = c_st_wake;
                end else begin
                    w_gap_nxt = r_gap_cnt + 8'd1;
                end
            end
            c_st_finish: begin
                w_state_nxt = c_st_idle;
                w_step_nxt  = 3'd0;
            end
            c_st_error: begin
                if (bus.start_i) begin
                    w_state_nxt = c_st_wake;
                    w_step_nxt  = 3'd0;
                    w_code_nxt  = c_err_none;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
                w_step_nxt  = 3'd0;
                w_code_nxt  = c_err_none;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_st_idle;
            r_step    <= 3'd0;
            r_gap_cnt <= 8'd0;
            r_code    <= c_err_none;
            r_wake    <= 3'b000;
            r_busy    <= 1'b0;
            r_finish  <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_step    <= w_step_nxt;
            r_gap_cnt <= w_gap_nxt;
            r_code    <= w_code_nxt;
            r_wake    <= (w_state_nxt == c_st_wake) ? agent_onehot(w_step_nxt) : 3'b000;
            r_busy    <= (w_state_nxt == c_st_wake) || (w_state_nxt == c_st_wait) ||
                         (w_state_nxt == c_st_gap)  || (w_state_nxt == c_st_finish);
            r_finish  <= (w_state_nxt == c_st_finish);
            r_err     <= (w_state_nxt == c_st_error);
        end
    end

    assign bus.wake_o     = r_wake;
    assign bus.step_o     = r_step;
    assign bus.busy_o     = r_busy;
    assign bus.finish_o   = r_finish;
    assign bus.err_o      = r_err;
    assign bus.err_code_o = r_code;

endmodule

`default_nettype wire

// File: doc/wake_sequencer.md
# wake_sequencer

Synthesizable event-ordering controller that drives three cooperating agents through a fixed six-step wake/done handshake sequence, then signals completion. It sits upstream of the three agent processes: it issues one-hot wake strobes and consumes their done pulses. It enforces that agents run strictly in the order 0,1,2,1,0,2 and raises a sticky error on any out-of-order, spurious or (optionally) late response.

## Interface
- DELAY, 1, idle gap in cycles between an accepted done and the next wake; range 0..255
- TIMEOUT, 64, maximum cycles in WAIT before timeout error; range 1..255
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- start_i  input  1  begin sequence; sampled in IDLE and ERROR only
- done_i  input  3  per-agent done pulses; bit k is agent k
- wake_o  output  3  one-hot wake strobe, high for exactly one cycle per step
- step_o  output  3  current step index 0..5
- busy_o  output  1  high in WAKE, WAIT, GAP and FINISH
- finish_o  output  1  one-cycle pulse after step 5 completes
- err_o  output  1  sticky error flag
- err_code_o  output  2  00 none, 01 wrong agent, 10 timeout, 11 spurious done

## Operation
- Step-to-agent map is fixed: step 0→agent 0, 1→1, 2→2, 3→1, 4→0, 5→2.
- All outputs are registered, Moore-decoded from state. Reset drives state IDLE, step_o=0, and wake_o, busy_o, finish_o, err_o and err_code_o to 0.
- IDLE: on start_i, go to WAKE with step=0. done_i is ignored.
- WAKE: wake_o = one-hot(agent(step)) for one cycle. Any done_i bit set goes to ERROR with code 11. Otherwise go to WAIT and clear the wait counter.
- WAIT: done_i equal to exactly the expected one-hot value is accepted.
  - If step=5, go to FINISH.
  - Otherwise increment step and go to GAP, or directly to WAKE when DELAY=0.
  - Any unexpected bit set, alone or together with the expected bit, goes to ERROR with code 01.
- GAP: a counter counts DELAY cycles, then the block goes to WAKE. Any done_i bit set goes to ERROR with code 11.
- FINISH: finish_o high for one cycle. Then step resets to 0 and the block goes to IDLE. done_i is ignored.
- ERROR: err_o=1, err_code_o holds the first error cause, wake_o=0, busy_o=0, and step_o freezes at the failing step. start_i clears err_o/err_code_o and restarts at step 0 in WAKE.
- start_i is ignored in all busy states.
- Asynchronous reset mid-sequence aborts immediately. No wake or finish pulse is emitted for the aborted sequence.

## Timing
- start_i sampled high at edge N: wake_o for step 0 is high during cycle N+1. WAIT begins at cycle N+2.
- done_i is accepted no earlier than the first WAIT cycle.
- done accepted at edge T:
  - the next wake_o is high in cycle T+1+DELAY;
  - for step 5, finish_o is high in cycle T+1 and busy_o drops in cycle T+2.
- Minimum total sequence length with DELAY=0 and done in the first WAIT cycle: 12 cycles from start to finish_o.
- Timeout: if no done arrives, ERROR is entered at the edge ending the TIMEOUT-th WAIT cycle. err_o is visible in the following cycle.
- Error entry takes one edge from the offending done_i sample. err_o is high in the next cycle.

## Configuration
- WAKE_SEQ_TIMEOUT_EN defined: the WAIT counter and the timeout error (code 10) are compiled in.
- WAKE_SEQ_TIMEOUT_EN undefined: the counter is removed and WAIT waits indefinitely. TIMEOUT is unused and code 10 is never produced. All other behaviour is identical.

## Test plan
- Nominal, DELAY=1: each agent returns done 2 cycles after its wake. Required: wake_o sequence 001,010,100,010,001,100; step_o 0..5; exactly one finish_o pulse; err_o=0; busy_o low afterwards.
- DELAY=0 with immediate done: wake pulses 2 cycles apart; finish_o 12 cycles after start_i.
- Wrong agent: after the step-0 wake, drive done_i=010. Required: err_o=1, err_code_o=01, step_o=0, no further wake. A subsequent start_i produces a clean full sequence.
- Timeout, TIMEOUT=8, macro defined: after the step-2 wake, withhold done. Required: err_code_o=10 exactly 8 WAIT cycles later. Macro undefined: busy_o stays high and err_o=0 for 100 cycles.
- Spurious done, DELAY=4: pulse done_i=001 during GAP after step 0. Required: err_code_o=11, step_o=1.
- Reset mid-operation: deassert rst_n during step 3 WAIT. Required: all outputs immediately 0. The next start_i begins at step 0 with wake_o=001.
